// File: rtl/checkers_pkg.sv
// Shared checkers definitions: nibble layout, start position, response codes
// and the board writer FSM encodings. Used by the writer, renderer and controller.
package checkers_pkg;

    localparam int BUF_W = 256;
    localparam int CNT_W = 4;

    // Bit positions inside one square nibble (bit3 is always 0)
    localparam int OCC_BIT   = 0;
    localparam int OWNER_BIT = 1;
    localparam int KING_BIT  = 2;

    localparam logic [CNT_W-1:0] START_COUNT = 4'd12;

    // Response codes returned to the game controller
    localparam logic [2:0] RSP_OK            = 3'd0;
    localparam logic [2:0] RSP_WRONG_TURN    = 3'd1;
    localparam logic [2:0] RSP_NO_OWN_PIECE  = 3'd2;
    localparam logic [2:0] RSP_DEST_OCCUPIED = 3'd3;
    localparam logic [2:0] RSP_BAD_GEOMETRY  = 3'd4;
    localparam logic [2:0] RSP_BAD_JUMP      = 3'd5;

    // Board writer FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Start position, one 32-bit word per row (row 7 first). Dark squares are
    // those with (row+col) odd; red (0001) on rows 0-2, green (0011) on rows 5-7.
    localparam logic [BUF_W-1:0] START_BOARD = {
        32'h0303_0303,   // row 7
        32'h3030_3030,   // row 6
        32'h0303_0303,   // row 5
        32'h0000_0000,   // row 4
        32'h0000_0000,   // row 3
        32'h1010_1010,   // row 2
        32'h0101_0101,   // row 1
        32'h1010_1010    // row 0
    };

    // Lowest buffer bit of a square's nibble: square s lives at [4s+3:4s]
    function automatic logic [7:0] nib_lsb(input logic [5:0] sq);
        return {sq, 2'b00};
    endfunction

endpackage

// File: rtl/move_checker.sv
// Combinational checkers rule evaluation for one move against the current board.
// Reports the first failing rule, plus jump / captured square / promotion info.
module move_checker
    import checkers_pkg::*;
(
    input  logic [BUF_W-1:0] board,
    input  logic             player,
    input  logic             turn,
    input  logic [5:0]       from,
    input  logic [5:0]       to,
    output logic [2:0]       code,
    output logic             is_jump,
    output logic [5:0]       mid_square,
    output logic             promote
);

    logic [2:0]        from_nib;
    logic              to_occ;
    logic [1:0]        mid_nib;
    logic signed [3:0] dr;
    logic signed [3:0] dc;
    logic [3:0]        adr;
    logic [3:0]        adc;
    logic              dir_ok;
    logic              step_shape;
    logic              jump_shape;
    logic              mid_opp;
    logic [2:0]        mid_row;
    logic [2:0]        mid_col;

    // Row/col deltas are taken on the fields, never on the linear index, so a
    // col 7 -> col 0 wrap shows up as dc = -7 and is rejected as bad geometry.
    always_comb begin
        from_nib = board[nib_lsb(from) +: 3];
        to_occ   = board[nib_lsb(to)];

        dr  = $signed({1'b0, to[5:3]}) - $signed({1'b0, from[5:3]});
        dc  = $signed({1'b0, to[2:0]}) - $signed({1'b0, from[2:0]});
        adr = dr[3] ? $unsigned(-dr) : $unsigned(dr);
        adc = dc[3] ? $unsigned(-dc) : $unsigned(dc);

        // Red moves up the rows, green down; kings go either way
        if (from_nib[KING_BIT])
            dir_ok = 1'b1;
        else if (player)
            dir_ok = dr[3];
        else
            dir_ok = !dr[3];

        step_shape = (adr == 4'd1) && (adc == 4'd1);
        jump_shape = (adr == 4'd2) && (adc == 4'd2);

        // Middle square is from + delta/2; only meaningful for a jump shape
        mid_row    = from[5:3] + {dr[2], dr[2:1]};
        mid_col    = from[2:0] + {dc[2], dc[2:1]};
        mid_square = {mid_row, mid_col};
        mid_nib    = board[nib_lsb(mid_square) +: 2];
        mid_opp    = mid_nib[OCC_BIT] && (mid_nib[OWNER_BIT] != player);

        is_jump = jump_shape;
        promote = player ? (to[5:3] == 3'd0) : (to[5:3] == 3'd7);

        if (player != turn)
            code = RSP_WRONG_TURN;
        else if (!from_nib[OCC_BIT] || (from_nib[OWNER_BIT] != player))
            code = RSP_NO_OWN_PIECE;
        else if (to_occ)
            code = RSP_DEST_OCCUPIED;
        else if (step_shape && dir_ok)
            code = RSP_OK;
        else if (jump_shape && dir_ok)
            code = mid_opp ? RSP_OK : RSP_BAD_JUMP;
        else
            code = RSP_BAD_GEOMETRY;
    end

endmodule

// File: rtl/board_state_writer.sv
// Owns the registered checkers board seen by the VGA renderer. Accepts one
// move command at a time, checks it, applies it and returns a status code.
//
// Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready;
// a response transfers on a cycle where rsp_valid && rsp_ready. rsp_valid and
// rsp_code are held stable until that transfer. cmd_ready is low outside IDLE
// and while new_game is asserted.
module board_state_writer
    import checkers_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_player,
    input  logic [5:0]       cmd_from,
    input  logic [5:0]       cmd_to,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_code,
    output logic [BUF_W-1:0] board_buffer,
    output logic             turn,
    output logic [CNT_W-1:0] red_count,
    output logic [CNT_W-1:0] green_count,
    output logic             game_over,
    output logic [1:0]       fsm_state
);

    logic [1:0]       state;
    logic             mv_player;
    logic [5:0]       mv_from;
    logic [5:0]       mv_to;
    logic [2:0]       code_q;
    logic             jump_q;
    logic [5:0]       mid_q;
    logic             promote_q;
    logic [2:0]       chk_code;
    logic             chk_jump;
    logic [5:0]       chk_mid;
    logic             chk_promote;
    logic [3:0]       moved_nib;
    logic [BUF_W-1:0] board_next;

    move_checker u_checker (
        .board      (board_buffer),
        .player     (mv_player),
        .turn       (turn),
        .from       (mv_from),
        .to         (mv_to),
        .code       (chk_code),
        .is_jump    (chk_jump),
        .mid_square (chk_mid),
        .promote    (chk_promote)
    );

    assign cmd_ready = (state == ST_IDLE) && !new_game;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_code  = code_q;
    assign fsm_state = state;

    // Board after the latched move: piece moves (possibly crowned), source and
    // any captured square are cleared. Only committed in APPLY when code is OK.
    always_comb begin
        moved_nib = board_buffer[nib_lsb(mv_from) +: 4];
        if (promote_q)
            moved_nib[KING_BIT] = 1'b1;
        board_next = board_buffer;
        board_next[nib_lsb(mv_from) +: 4] = 4'b0000;
        if (jump_q)
            board_next[nib_lsb(mid_q) +: 4] = 4'b0000;
        board_next[nib_lsb(mv_to) +: 4] = moved_nib;
    end

    // Command FSM, board register, turn and piece counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            board_buffer <= START_BOARD;
            turn         <= 1'b0;
            red_count    <= START_COUNT;
            green_count  <= START_COUNT;
            game_over    <= 1'b0;
            code_q       <= RSP_OK;
            jump_q       <= 1'b0;
            mid_q        <= 6'd0;
            promote_q    <= 1'b0;
            mv_player    <= 1'b0;
            mv_from      <= 6'd0;
            mv_to        <= 6'd0;
        end else begin
            game_over <= (red_count == '0) || (green_count == '0);
            case (state)
                ST_IDLE: begin
                    if (new_game) begin
                        board_buffer <= START_BOARD;
                        turn         <= 1'b0;
                        red_count    <= START_COUNT;
                        green_count  <= START_COUNT;
                        game_over    <= 1'b0;
                    end else if (cmd_valid) begin
                        mv_player <= cmd_player;
                        mv_from   <= cmd_from;
                        mv_to     <= cmd_to;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    code_q    <= chk_code;
                    jump_q    <= chk_jump;
                    mid_q     <= chk_mid;
                    promote_q <= chk_promote;
                    state     <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (code_q == RSP_OK) begin
                        board_buffer <= board_next;
                        turn         <= ~turn;
                        if (jump_q) begin
                            if (mv_player)
                                red_count <= red_count - CNT_W'(1);
                            else
                                green_count <= green_count - CNT_W'(1);
                        end
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_state_writer.sv
// Directed bench for board_state_writer: a table of move commands with
// hand-computed results, plus hand-written timing / reset / new_game sequences.
module tb_board_state_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_game;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_player;
    logic [5:0]   cmd_from;
    logic [5:0]   cmd_to;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [2:0]   rsp_code;
    logic [255:0] board_buffer;
    logic         turn;
    logic [3:0]   red_count;
    logic [3:0]   green_count;
    logic         game_over;
    logic [1:0]   fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [255:0] start_ref;
    logic [2:0]   exp_q[$];

    typedef struct packed {
        logic       rst;
        logic       player;
        logic [5:0] from;
        logic [5:0] to;
        logic [2:0] code;
        logic       turn;
        logic [5:0] sq_a;
        logic [3:0] nib_a;
        logic [5:0] sq_b;
        logic [3:0] nib_b;
        logic [3:0] red;
        logic [3:0] green;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    board_state_writer dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_player   (cmd_player),
        .cmd_from     (cmd_from),
        .cmd_to       (cmd_to),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_code     (rsp_code),
        .board_buffer (board_buffer),
        .turn         (turn),
        .red_count    (red_count),
        .green_count  (green_count),
        .game_over    (game_over),
        .fsm_state    (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input int rst, input int p, input int f, input int t,
                                input int c, input int tn, input int sa, input int na,
                                input int sb, input int nb, input int r, input int g);
        vec_t v;
        v.rst = 1'(rst);  v.player = 1'(p);  v.from = 6'(f);  v.to = 6'(t);
        v.code = 3'(c);   v.turn = 1'(tn);   v.sq_a = 6'(sa); v.nib_a = 4'(na);
        v.sq_b = 6'(sb);  v.nib_b = 4'(nb);  v.red = 4'(r);   v.green = 4'(g);
        return v;
    endfunction

    function automatic logic [3:0] nib_of(input logic [255:0] b, input int s);
        return b[s*4 +: 4];
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reset: leaves the bench at #1 after the first edge with reset released
    task automatic do_reset();
        reset = 1'b0; new_game = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_player = 1'b0; cmd_from = 6'd0; cmd_to = 6'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Driver: one command, full response handshake with rsp_ready high.
    // Entered and left at #1 after a rising edge.
    task automatic send_cmd(input logic p, input logic [5:0] f, input logic [5:0] t,
                            output logic [2:0] code, output logic got);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_ready_wait", 256'(cmd_ready), 256'(1));
        cmd_valid = 1'b1; cmd_player = p; cmd_from = f; cmd_to = t; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        got  = rsp_valid;
        code = rsp_code;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] code;
        logic       got;
        logic [2:0] exp_code;

        // Reference start position derived from the dark-square rule
        start_ref = '0;
        for (int s = 0; s < 64; s++) begin
            int r, c;
            r = s / 8; c = s % 8;
            if (((r + c) % 2) == 1) begin
                if (r < 3)      start_ref[s*4 +: 4] = 4'b0001;
                else if (r > 4) start_ref[s*4 +: 4] = 4'b0011;
            end
        end

        // Group A: wrong turn, first red move
        vecs[0]  = mk(1, 1, 40, 33, 1, 0, 40, 3, 33, 0, 12, 12);
        vecs[1]  = mk(0, 0, 17, 24, 0, 1, 24, 1, 17, 0, 12, 12);
        // Group B: wrap, empty source, occupied destination
        vecs[2]  = mk(1, 0, 23, 24, 4, 0, 23, 1, 24, 0, 12, 12);
        vecs[3]  = mk(0, 0, 16, 25, 2, 0, 16, 0, 25, 0, 12, 12);
        vecs[4]  = mk(0, 0, 17, 10, 3, 0, 17, 1, 10, 1, 12, 12);
        // Group C: scripted game with captures, promotion and king moves
        vecs[5]  = mk(1, 0, 21, 28, 0, 1, 28, 1, 21, 0, 12, 12);
        vecs[6]  = mk(0, 1, 44, 37, 0, 0, 37, 3, 44, 0, 12, 12);
        vecs[7]  = mk(0, 0, 28, 35, 0, 1, 35, 1, 28, 0, 12, 12);
        vecs[8]  = mk(0, 1, 42, 28, 0, 0, 28, 3, 35, 0, 11, 12);
        vecs[9]  = mk(0, 0, 14, 21, 0, 1, 21, 1, 14, 0, 11, 12);
        vecs[10] = mk(0, 1, 37, 30, 0, 0, 30, 3, 37, 0, 11, 12);
        vecs[11] = mk(0, 0, 21, 39, 0, 1, 39, 1, 30, 0, 11, 11);
        vecs[12] = mk(0, 1, 53, 44, 0, 0, 44, 3, 53, 0, 11, 11);
        vecs[13] = mk(0, 0, 39, 53, 0, 1, 53, 1, 46, 0, 11, 10);
        vecs[14] = mk(0, 1, 55, 46, 0, 0, 46, 3, 55, 0, 11, 10);
        vecs[15] = mk(0, 0, 12, 21, 0, 1, 21, 1, 12, 0, 11, 10);
        vecs[16] = mk(0, 1, 62, 55, 0, 0, 55, 3, 62, 0, 11, 10);
        vecs[17] = mk(0, 0, 53, 62, 0, 1, 62, 5, 53, 0, 11, 10);
        vecs[18] = mk(0, 1, 44, 35, 0, 0, 35, 3, 44, 0, 11, 10);
        vecs[19] = mk(0, 0, 21, 12, 4, 0, 21, 1, 12, 0, 11, 10);
        vecs[20] = mk(0, 0, 62, 53, 0, 1, 53, 5, 62, 0, 11, 10);
        vecs[21] = mk(0, 1, 51, 33, 5, 1, 51, 3, 33, 0, 11, 10);

        // Reset state
        do_reset();
        check("rst_board",     board_buffer,      start_ref);
        check("rst_turn",      256'(turn),        256'(0));
        check("rst_red",       256'(red_count),   256'(12));
        check("rst_green",     256'(green_count), 256'(12));
        check("rst_cmd_ready", 256'(cmd_ready),   256'(1));
        check("rst_rsp_valid", 256'(rsp_valid),   256'(0));
        check("rst_rsp_code",  256'(rsp_code),    256'(0));
        check("rst_game_over", 256'(game_over),   256'(0));
        check("rst_fsm_state", 256'(fsm_state),   256'(0));

        // Table of commands
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst) do_reset();
            exp_q.push_back(vecs[i].code);
            send_cmd(vecs[i].player, vecs[i].from, vecs[i].to, code, got);
            exp_code = exp_q.pop_front();
            check($sformatf("v%0d_rsp_seen", i), 256'(got), 256'(1));
            check($sformatf("v%0d_code", i),  256'(code), 256'(exp_code));
            check($sformatf("v%0d_turn", i),  256'(turn), 256'(vecs[i].turn));
            check($sformatf("v%0d_sq%0d", i, vecs[i].sq_a),
                  256'(nib_of(board_buffer, int'(vecs[i].sq_a))), 256'(vecs[i].nib_a));
            check($sformatf("v%0d_sq%0d", i, vecs[i].sq_b),
                  256'(nib_of(board_buffer, int'(vecs[i].sq_b))), 256'(vecs[i].nib_b));
            check($sformatf("v%0d_red", i),   256'(red_count),   256'(vecs[i].red));
            check($sformatf("v%0d_green", i), 256'(green_count), 256'(vecs[i].green));
            check($sformatf("v%0d_game_over", i), 256'(game_over), 256'(0));
            if (i == 0)
                check("wrong_turn_board_unchanged", board_buffer, start_ref);
        end

        // new_game beats a simultaneous command and restores the start position
        cmd_valid = 1'b1; cmd_player = 1'b1; cmd_from = 6'd40; cmd_to = 6'd33;
        new_game = 1'b1;
        #1 check("ng_cmd_ready_low", 256'(cmd_ready), 256'(0));
        @(posedge clk); #1;
        new_game = 1'b0; cmd_valid = 1'b0;
        check("ng_board", board_buffer,      start_ref);
        check("ng_turn",  256'(turn),        256'(0));
        check("ng_red",   256'(red_count),   256'(12));
        check("ng_green", 256'(green_count), 256'(12));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("ng_no_rsp_%0d", k), 256'(rsp_valid), 256'(0));
        end

        // Latency and held response: rsp_valid first seen in cycle 3 after accept
        do_reset();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_player = 1'b0; cmd_from = 6'd17; cmd_to = 6'd24;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("lat_c1_rsp_valid", 256'(rsp_valid), 256'(0));
        check("lat_c1_cmd_ready", 256'(cmd_ready), 256'(0));
        @(posedge clk); #1;
        check("lat_c2_rsp_valid", 256'(rsp_valid), 256'(0));
        check("lat_c2_board",     board_buffer,    start_ref);
        @(posedge clk); #1;
        check("lat_c3_rsp_valid", 256'(rsp_valid), 256'(1));
        check("lat_c3_code",      256'(rsp_code),  256'(0));
        check("lat_c3_sq24",      256'(nib_of(board_buffer, 24)), 256'(1));
        check("lat_c3_sq17",      256'(nib_of(board_buffer, 17)), 256'(0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_%0d_rsp_valid", k), 256'(rsp_valid), 256'(1));
            check($sformatf("hold_%0d_rsp_code", k),  256'(rsp_code),  256'(0));
            check($sformatf("hold_%0d_cmd_ready", k), 256'(cmd_ready), 256'(0));
            check($sformatf("hold_%0d_turn", k),      256'(turn),      256'(1));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_rsp_valid", 256'(rsp_valid), 256'(0));
        check("hold_release_cmd_ready", 256'(cmd_ready), 256'(1));

        // Reset asserted while the command sits in APPLY aborts it
        do_reset();
        cmd_valid = 1'b1; cmd_player = 1'b0; cmd_from = 6'd17; cmd_to = 6'd24;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_apply", 256'(fsm_state), 256'(2));
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort_%0d_rsp_valid", k), 256'(rsp_valid), 256'(0));
            @(posedge clk); #1;
        end
        check("abort_board",     board_buffer,    start_ref);
        check("abort_turn",      256'(turn),      256'(0));
        check("abort_cmd_ready", 256'(cmd_ready), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends on its own
    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
